// File: rtl/fclk_align.sv
// fclk_align: frame-clock word aligner driving deserializer bitslip.
// Ports: divclk/rst (sync, active-high), fclk_deser word, restart,
//   bitslip pulse, aligned, align_err, slip_count.
module fclk_align #(
   parameter logic [7:0]  EXPECTED_PATTERN = 8'hF0,
   parameter int unsigned LOCK_COUNT       = 16,
   parameter int unsigned LOSS_COUNT       = 4,
   parameter int unsigned SETTLE_CYCLES    = 4,
   parameter int unsigned MAX_SLIPS        = 8
) (
   input  logic       divclk,
   input  logic       rst,
   input  logic [7:0] fclk_deser,
   input  logic       restart,
   output logic       bitslip,
   output logic       aligned,
   output logic       align_err,
   output logic [3:0] slip_count
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [MW-1:0] LOCK_LAST =
      MW'(LOCK_COUNT - 1);
   localparam logic [LW-1:0] LOSS_LAST =
      LW'(LOSS_COUNT - 1);
   localparam logic [SW-1:0] SETTLE_LOAD =
      SW'(SETTLE_CYCLES - 1);
   localparam logic [3:0] SLIP_MAX =
      4'(MAX_SLIPS);

   typedef enum logic [2:0] {
      S_CHECK,
      S_SLIP,
      S_SETTLE,
      S_LOCKED,
      S_FAIL
   } state_t;

   state_t        state_q, state_d;
   logic [MW-1:0] match_q, match_d;
   logic [LW-1:0] miss_q, miss_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [3:0]    slips_q, slips_d;

   logic bitslip_q, bitslip_d;
   logic aligned_q, aligned_d;
   logic err_q, err_d;

   logic is_match;

   assign is_match = (fclk_deser == EXPECTED_PATTERN);

   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      miss_d   = miss_q;
      settle_d = settle_q;
      slips_d  = slips_q;

      if (restart) begin
         state_d  = S_CHECK;
         match_d  = '0;
         miss_d   = '0;
         settle_d = '0;
         slips_d  = '0;
      end else begin
         unique case (state_q)
            S_CHECK: begin
               if (is_match) begin
                  if (match_q == LOCK_LAST) begin
                     state_d = S_LOCKED;
                     match_d = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
                  if (slips_q == SLIP_MAX) begin
                     state_d = S_FAIL;
                  end else begin
                     state_d = S_SLIP;
                  end
               end
            end

            S_SLIP: begin
               slips_d  = slips_q + 1'b1;
               settle_d = SETTLE_LOAD;
               state_d  = S_SETTLE;
            end

            // Words are still in flux after a slip; ignore them.
            S_SETTLE: begin
               if (settle_q == '0) begin
                  state_d = S_CHECK;
               end else begin
                  settle_d = settle_q - 1'b1;
               end
            end

            S_LOCKED: begin
               if (is_match) begin
                  miss_d = '0;
               end else if (miss_q == LOSS_LAST) begin
                  state_d = S_CHECK;
                  miss_d  = '0;
                  match_d = '0;
                  slips_d = '0;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
            end

            S_FAIL: begin
               state_d = S_FAIL;
            end

            default: begin
               state_d = S_CHECK;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so that
   // they are registered yet line up with the state.
   always_comb begin
      bitslip_d = (state_d == S_SLIP);
      aligned_d = (state_d == S_LOCKED);
      err_d     = (state_d == S_FAIL);
   end

   always_ff @(posedge divclk) begin
      if (rst) begin
         state_q   <= S_CHECK;
         match_q   <= '0;
         miss_q    <= '0;
         settle_q  <= '0;
         slips_q   <= '0;
         bitslip_q <= 1'b0;
         aligned_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         settle_q  <= settle_d;
         slips_q   <= slips_d;
         bitslip_q <= bitslip_d;
         aligned_q <= aligned_d;
         err_q     <= err_d;
      end
   end

   assign bitslip    = bitslip_q;
   assign aligned    = aligned_q;
   assign align_err  = err_q;
   assign slip_count = slips_q;

endmodule

// File: tb/tb_fclk_align.sv
// tb_fclk_align: directed bench for fclk_align with a
// cycle-level behavioural model and literal checks.
module tb_fclk_align;

   localparam logic [7:0] PAT = 8'hF0;
   localparam int LOCK   = 16;
   localparam int LOSS   = 4;
   localparam int SETTLE = 4;
   localparam int MAXS   = 8;

   logic       clk;
   logic       rst;
   logic       restart;
   logic [7:0] fclk_drv;
   logic [7:0] fclk_in;
   logic       bitslip;
   logic       aligned;
   logic       align_err;
   logic [3:0] slip_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   fclk_align #(
      .EXPECTED_PATTERN(PAT),
      .LOCK_COUNT(LOCK),
      .LOSS_COUNT(LOSS),
      .SETTLE_CYCLES(SETTLE),
      .MAX_SLIPS(MAXS)
   ) dut (
      .divclk(clk),
      .rst(rst),
      .fclk_deser(fclk_in),
      .restart(restart),
      .bitslip(bitslip),
      .aligned(aligned),
      .align_err(align_err),
      .slip_count(slip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm,
                      input int act,
                      input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] rotl(
      input logic [7:0] v, input int r);
      logic [7:0] t;
      t = v;
      for (int i = 0; i < r; i++) t = {t[6:0], t[7]};
      return t;
   endfunction

   // Deserializer stand-in: word starts rotated by 3 and
   // each bitslip takes effect two cycles later.
   logic deser_en = 1'b0;
   int   rot = 3;
   int   lat = 0;

   always @(negedge clk) begin
      if (!deser_en) begin
         rot = 3;
         lat = 0;
      end else if (bitslip) begin
         lat = 2;
      end else if (lat > 0) begin
         lat--;
         if (lat == 0 && rot > 0) rot--;
      end
   end

   always_comb begin
      fclk_in = deser_en ? rotl(PAT, rot) : fclk_drv;
   end

   // Behavioural model in terms of runs and blind windows.
   bit m_started = 0;
   bit m_locked  = 0;
   bit m_failed  = 0;
   bit m_bs      = 0;
   int m_slips   = 0;
   int m_run     = 0;
   int m_miss    = 0;
   int m_blind   = 0;

   always @(posedge clk) begin
      if (rst || restart) begin
         m_started = 1;
         m_locked  = 0;
         m_failed  = 0;
         m_bs      = 0;
         m_slips   = 0;
         m_run     = 0;
         m_miss    = 0;
         m_blind   = 0;
      end else if (m_started) begin
         if (m_blind > 0) begin
            if (m_bs) begin
               m_bs = 0;
               m_slips++;
            end
            m_blind--;
         end else if (m_failed) begin
            m_bs = 0;
         end else if (m_locked) begin
            if (fclk_in == PAT) begin
               m_miss = 0;
            end else begin
               m_miss++;
               if (m_miss == LOSS) begin
                  m_locked = 0;
                  m_miss   = 0;
                  m_run    = 0;
                  m_slips  = 0;
               end
            end
         end else if (fclk_in == PAT) begin
            m_run++;
            if (m_run == LOCK) begin
               m_locked = 1;
               m_run    = 0;
            end
         end else begin
            m_run = 0;
            if (m_slips == MAXS) begin
               m_failed = 1;
            end else begin
               m_bs    = 1;
               m_blind = SETTLE + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("m_bitslip", int'(bitslip), int'(m_bs));
         chk("m_aligned", int'(aligned), int'(m_locked));
         chk("m_align_err", int'(align_err),
             int'(m_failed));
         chk("m_slip_count", int'(slip_count), m_slips);
      end
   end

   int pulse_q[$];

   always @(negedge clk) begin
      if (bitslip) pulse_q.push_back(cyc);
   end

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int base;

   initial begin
      rst      = 1'b1;
      restart  = 1'b0;
      fclk_drv = PAT;

      // Reset state, then lock on a clean pattern.
      @(negedge clk);
      chk("rst_aligned", int'(aligned), 0);
      chk("rst_slip_count", int'(slip_count), 0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("lock_e15", int'(aligned), 0);
      @(negedge clk);
      chk("lock_e16", int'(aligned), 1);
      chk("lock_pulses", pulse_q.size(), 0);
      chk("lock_slips", int'(slip_count), 0);

      // Three misses keep lock; four drop it.
      fclk_drv = 8'h00;
      repeat (3) @(negedge clk);
      fclk_drv = PAT;
      chk("miss3_aligned", int'(aligned), 1);
      repeat (5) @(negedge clk);
      fclk_drv = 8'h00;
      repeat (3) @(negedge clk);
      chk("miss3b_aligned", int'(aligned), 1);
      @(negedge clk);
      chk("miss4_aligned", int'(aligned), 0);
      chk("miss4_slips", int'(slip_count), 0);
      fclk_drv = PAT;
      base = pulse_q.size();
      repeat (15) @(negedge clk);
      chk("reacq_e15", int'(aligned), 0);
      @(negedge clk);
      chk("reacq_e16", int'(aligned), 1);
      chk("reacq_pulses", pulse_q.size(), base);

      // Ten matches, one miss, then a fresh lock run.
      fclk_drv = PAT;
      do_reset();
      repeat (10) @(negedge clk);
      fclk_drv = 8'h00;
      @(negedge clk);
      chk("acq_bitslip", int'(bitslip), 1);
      fclk_drv = PAT;
      repeat (20) @(negedge clk);
      chk("acq_e31", int'(aligned), 0);
      @(negedge clk);
      chk("acq_e32", int'(aligned), 1);

      // Rotated pattern needs three slips.
      deser_en = 1'b1;
      do_reset();
      base = pulse_q.size();
      repeat (40) @(negedge clk);
      chk("rot_pulses", pulse_q.size() - base, 3);
      if (pulse_q.size() - base >= 3) begin
         chk("rot_gap1",
             pulse_q[base+1] - pulse_q[base], 6);
         chk("rot_gap2",
             pulse_q[base+2] - pulse_q[base+1], 6);
      end
      chk("rot_aligned", int'(aligned), 1);
      chk("rot_slips", int'(slip_count), 3);
      deser_en = 1'b0;

      // No slip position matches: fail, then restart.
      fclk_drv = 8'hAA;
      do_reset();
      base = pulse_q.size();
      repeat (55) @(negedge clk);
      chk("fail_pulses", pulse_q.size() - base, 8);
      chk("fail_err", int'(align_err), 1);
      chk("fail_slips", int'(slip_count), 8);
      repeat (100) @(negedge clk);
      chk("fail_hold", pulse_q.size() - base, 8);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("rs_err", int'(align_err), 0);
      chk("rs_slips", int'(slip_count), 0);
      @(negedge clk);
      chk("rs_bitslip", int'(bitslip), 1);

      // Reset with restart while in SETTLE.
      repeat (2) @(negedge clk);
      rst     = 1'b1;
      restart = 1'b1;
      @(negedge clk);
      chk("st_bitslip", int'(bitslip), 0);
      chk("st_aligned", int'(aligned), 0);
      chk("st_err", int'(align_err), 0);
      chk("st_slips", int'(slip_count), 0);
      rst      = 1'b0;
      restart  = 1'b0;
      fclk_drv = PAT;
      base = pulse_q.size();
      repeat (16) @(negedge clk);
      chk("st_pulses", pulse_q.size(), base);
      chk("st_lock", int'(aligned), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
